// File: rtl/pipeline_ctrl_if.sv
// Stall, hazard and redirect signals exchanged between the pipeline stages and pipeline_ctrl.
// The pipeline drives through master; the controller receives through slave.
interface pipeline_ctrl_if;
  logic        pause_req_if;
  logic        pause_req_id;
  logic        pause_req_ex;
  logic        pause_req_mem;
  logic        hold;
  logic        excp_valid;
  logic [31:0] excp_pc;
  logic        br_valid;
  logic [31:0] br_pc;
  logic [5:0]  pause;
  logic        flush;
  logic        flush_front;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] stall_cnt;
  logic        timeout;

  modport master (
    output pause_req_if, pause_req_id, pause_req_ex, pause_req_mem, hold,
           excp_valid, excp_pc, br_valid, br_pc,
    input  pause, flush, flush_front, redirect_valid, redirect_pc, stall_cnt, timeout
  );

  modport slave (
    input  pause_req_if, pause_req_id, pause_req_ex, pause_req_mem, hold,
           excp_valid, excp_pc, br_valid, br_pc,
    output pause, flush, flush_front, redirect_valid, redirect_pc, stall_cnt, timeout
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: stage pause vector, exception/branch redirect with
// pending capture, a saturating stall counter and a consecutive-stall watchdog.
module pipeline_ctrl #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic           clk,
  input  logic           rst,
  pipeline_ctrl_if.slave bus
);
  localparam logic [31:0] TO = 32'(TIMEOUT);

  typedef enum logic [1:0] {RUN, FLUSH, FRONT} state_e;

  state_e      state_q, state_d;
  logic        flush_q, flush_d;
  logic        front_q, front_d;
  logic        rv_q, rv_d;
  logic [31:0] rpc_q, rpc_d;
  logic        excp_pend_q, excp_pend_d;
  logic [31:0] excp_ppc_q, excp_ppc_d;
  logic        br_pend_q, br_pend_d;
  logic [31:0] br_ppc_q, br_ppc_d;
  logic [31:0] stall_q, stall_d;
  logic [31:0] run_q, run_d;
  logic        tmo_q, tmo_d;

  logic [5:0]  pause_raw, pause_w;
  logic        excp_here, br_here, excp_acc, br_acc;
  logic [31:0] excp_tgt, br_tgt;

  always_comb begin
    pause_raw = '0;
    if (bus.hold)               pause_raw = 6'b111111;
    else if (bus.pause_req_mem) pause_raw = 6'b011111;
    else if (bus.pause_req_ex)  pause_raw = 6'b001111;
    else if (bus.pause_req_id)  pause_raw = 6'b000111;
    else if (bus.pause_req_if)  pause_raw = 6'b000011;
  end

  // A flushing cycle squashes every stall except a debug halt.
  assign pause_w = (flush_q && !bus.hold) ? '0 : pause_raw;

  always_comb begin
    excp_here = bus.excp_valid || excp_pend_q;
    excp_tgt  = bus.excp_valid ? bus.excp_pc : excp_ppc_q;
    br_here   = bus.br_valid || br_pend_q;
    br_tgt    = bus.br_valid ? bus.br_pc : br_ppc_q;
    excp_acc  = (state_q == RUN) && excp_here && !bus.pause_req_mem && !bus.hold;
    br_acc    = (state_q == RUN) && br_here && !pause_w[3] && !excp_acc;

    state_d     = RUN;
    excp_pend_d = excp_pend_q;
    excp_ppc_d  = excp_ppc_q;
    br_pend_d   = br_pend_q;
    br_ppc_d    = br_ppc_q;

    unique case (state_q)
      RUN: begin
        if (excp_acc) begin
          state_d     = FLUSH;
          excp_pend_d = 1'b0;
          br_pend_d   = 1'b0;
        end else begin
          if (excp_here) begin
            excp_pend_d = 1'b1;
            excp_ppc_d  = excp_tgt;
          end
          if (br_acc) begin
            state_d   = FRONT;
            br_pend_d = 1'b0;
          end else if (br_here) begin
            br_pend_d = 1'b1;
            br_ppc_d  = br_tgt;
          end
        end
      end
      FRONT: begin
        if (bus.excp_valid) begin
          excp_pend_d = 1'b1;
          excp_ppc_d  = bus.excp_pc;
        end
      end
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase

    flush_d = excp_acc;
    front_d = br_acc;
    rv_d    = excp_acc || br_acc;
    rpc_d   = excp_acc ? excp_tgt : (br_acc ? br_tgt : rpc_q);

    stall_d = stall_q;
    if (pause_w != '0 && stall_q != '1) stall_d = stall_q + 32'd1;

    // Watchdog only counts stalls not explained by a debug halt.
    run_d = '0;
    if (pause_w != '0 && !bus.hold) run_d = (run_q == TO) ? run_q : run_q + 32'd1;
    tmo_d = tmo_q || (run_d == TO);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      flush_q     <= 1'b0;
      front_q     <= 1'b0;
      rv_q        <= 1'b0;
      rpc_q       <= '0;
      excp_pend_q <= 1'b0;
      excp_ppc_q  <= '0;
      br_pend_q   <= 1'b0;
      br_ppc_q    <= '0;
      stall_q     <= '0;
      run_q       <= '0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_q     <= flush_d;
      front_q     <= front_d;
      rv_q        <= rv_d;
      rpc_q       <= rpc_d;
      excp_pend_q <= excp_pend_d;
      excp_ppc_q  <= excp_ppc_d;
      br_pend_q   <= br_pend_d;
      br_ppc_q    <= br_ppc_d;
      stall_q     <= stall_d;
      run_q       <= run_d;
      tmo_q       <= tmo_d;
    end
  end

  assign bus.pause          = pause_w;
  assign bus.flush          = flush_q;
  assign bus.flush_front    = front_q;
  assign bus.redirect_valid = rv_q;
  assign bus.redirect_pc    = rpc_q;
  assign bus.stall_cnt      = stall_q;
  assign bus.timeout        = tmo_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: redirect events are scoreboarded with their expected
// cycle; pause, stall counter and watchdog are checked directly.
module tb_pipeline_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int unsigned cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int unsigned cyc;
    logic        fl;
    logic        ff;
    logic [31:0] pc;
  } exp_t;
  exp_t sb[$];

  pipeline_ctrl_if bus ();

  pipeline_ctrl #(.TIMEOUT(1024)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void expect_redirect(input int unsigned c, input logic fl,
                                          input logic ff, input logic [31:0] pc);
    exp_t e;
    e.cyc = c; e.fl = fl; e.ff = ff; e.pc = pc;
    sb.push_back(e);
  endfunction

  // Monitor: every flush/flush_front/redirect pulse must match the next expectation.
  always @(negedge clk) begin
    if (rst && (bus.redirect_valid || bus.flush || bus.flush_front)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_redirect: cyc %0d flush=%b front=%b rv=%b pc=%h, expected no event",
                 cyc, bus.flush, bus.flush_front, bus.redirect_valid, bus.redirect_pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (cyc != e.cyc || bus.flush !== e.fl || bus.flush_front !== e.ff ||
            bus.redirect_valid !== 1'b1 || bus.redirect_pc !== e.pc) begin
          errors++;
          $display("FAIL redirect_event: got cyc %0d flush=%b front=%b rv=%b pc=%h expected cyc %0d flush=%b front=%b rv=1 pc=%h",
                   cyc, bus.flush, bus.flush_front, bus.redirect_valid, bus.redirect_pc,
                   e.cyc, e.fl, e.ff, e.pc);
        end
      end
    end
  end

  logic [4:0] pvec [9] = '{5'b00000, 5'b00001, 5'b00010, 5'b00100, 5'b01000,
                           5'b01010, 5'b10000, 5'b11111, 5'b00011};
  logic [5:0] pexp [9] = '{6'h00, 6'h03, 6'h07, 6'h0F, 6'h1F,
                           6'h1F, 6'h3F, 6'h3F, 6'h07};

  initial begin
    bus.pause_req_if = 0; bus.pause_req_id = 0; bus.pause_req_ex = 0; bus.pause_req_mem = 0;
    bus.hold = 0; bus.excp_valid = 0; bus.excp_pc = '0; bus.br_valid = 0; bus.br_pc = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_flush", 32'(bus.flush), 32'd0);
    check("rst_front", 32'(bus.flush_front), 32'd0);
    check("rst_rv", 32'(bus.redirect_valid), 32'd0);
    check("rst_rpc", bus.redirect_pc, 32'h0);
    check("rst_stall", bus.stall_cnt, 32'h0);
    check("rst_timeout", 32'(bus.timeout), 32'd0);
    bus.pause_req_mem = 1;
    #1 check("rst_pause_follows", 32'(bus.pause), 32'h1F);
    bus.pause_req_mem = 0;
    rst = 1;
    step();

    // {hold, mem, ex, id, if} -> pause
    for (int i = 0; i < 9; i++) begin
      {bus.hold, bus.pause_req_mem, bus.pause_req_ex, bus.pause_req_id, bus.pause_req_if} = pvec[i];
      #1 check($sformatf("pause_vec%0d", i), 32'(bus.pause), 32'(pexp[i]));
      step();
    end
    {bus.hold, bus.pause_req_mem, bus.pause_req_ex, bus.pause_req_id, bus.pause_req_if} = '0;
    idle(2);

    // Exception, no stalls; pause squashed during flush unless halted.
    bus.excp_valid = 1; bus.excp_pc = 32'h1C00_0100;
    expect_redirect(cyc + 1, 1, 0, 32'h1C00_0100);
    step();
    bus.excp_valid = 0;
    bus.pause_req_ex = 1;
    #1 check("pause_during_flush", 32'(bus.pause), 32'h00);
    bus.hold = 1;
    #1 check("pause_hold_during_flush", 32'(bus.pause), 32'h3F);
    bus.hold = 0; bus.pause_req_ex = 0;
    step();
    check("excp_flush_drop", 32'({bus.flush, bus.redirect_valid}), 32'd0);
    idle(2);

    // Branch, no stalls.
    bus.br_valid = 1; bus.br_pc = 32'h0000_2000;
    expect_redirect(cyc + 1, 0, 1, 32'h0000_2000);
    step();
    bus.br_valid = 0;
    idle(2);

    // Exception blocked by MEM stall for four cycles.
    bus.pause_req_mem = 1; bus.excp_valid = 1; bus.excp_pc = 32'h0000_3000;
    step();
    bus.excp_valid = 0;
    idle(3);
    bus.pause_req_mem = 0;
    expect_redirect(cyc + 1, 1, 0, 32'h0000_3000);
    idle(3);

    // Newer exception overwrites the pending target while halted.
    bus.hold = 1; bus.excp_valid = 1; bus.excp_pc = 32'h0000_4000;
    step();
    bus.excp_pc = 32'h0000_5000;
    step();
    bus.excp_valid = 0; bus.hold = 0;
    expect_redirect(cyc + 1, 1, 0, 32'h0000_5000);
    idle(3);

    // Branch held pending behind an EX stall.
    bus.pause_req_ex = 1; bus.br_valid = 1; bus.br_pc = 32'h0000_2400;
    step();
    bus.br_valid = 0;
    step();
    bus.pause_req_ex = 0;
    expect_redirect(cyc + 1, 0, 1, 32'h0000_2400);
    idle(3);

    // Simultaneous exception and branch: exception only.
    bus.excp_valid = 1; bus.excp_pc = 32'h80; bus.br_valid = 1; bus.br_pc = 32'h40;
    expect_redirect(cyc + 1, 1, 0, 32'h80);
    step();
    bus.excp_valid = 0; bus.br_valid = 0;
    idle(3);

    // Pending branch discarded by an accepted exception.
    bus.pause_req_ex = 1; bus.br_valid = 1; bus.br_pc = 32'h44;
    step();
    bus.br_valid = 0; bus.excp_valid = 1; bus.excp_pc = 32'h88;
    expect_redirect(cyc + 1, 1, 0, 32'h88);
    step();
    bus.excp_valid = 0; bus.pause_req_ex = 0;
    idle(3);

    // Branch arriving during FLUSH is dropped.
    bus.excp_valid = 1; bus.excp_pc = 32'h90;
    expect_redirect(cyc + 1, 1, 0, 32'h90);
    step();
    bus.excp_valid = 0; bus.br_valid = 1; bus.br_pc = 32'h94;
    step();
    bus.br_valid = 0;
    idle(3);

    // Exception arriving during FRONT is latched and taken afterwards.
    bus.br_valid = 1; bus.br_pc = 32'hA0;
    expect_redirect(cyc + 1, 0, 1, 32'hA0);
    step();
    bus.br_valid = 0; bus.excp_valid = 1; bus.excp_pc = 32'hA4;
    expect_redirect(cyc + 2, 1, 0, 32'hA4);
    step();
    bus.excp_valid = 0;
    idle(3);

    // Reset mid-stall with an exception pending.
    bus.pause_req_mem = 1; bus.excp_valid = 1; bus.excp_pc = 32'h6000;
    step();
    bus.excp_valid = 0;
    step();
    rst = 0;
    #1;
    check("midrst_flush", 32'(bus.flush), 32'd0);
    check("midrst_rv", 32'(bus.redirect_valid), 32'd0);
    check("midrst_rpc", bus.redirect_pc, 32'h0);
    check("midrst_stall", bus.stall_cnt, 32'h0);
    bus.pause_req_mem = 0;
    step();
    rst = 1;
    idle(5);
    check("postrst_rv", 32'(bus.redirect_valid), 32'd0);

    // Watchdog at TIMEOUT consecutive EX stalls.
    bus.pause_req_ex = 1;
    idle(1023);
    check("timeout_before", 32'(bus.timeout), 32'd0);
    check("stall_1023", bus.stall_cnt, 32'd1023);
    step();
    check("timeout_set", 32'(bus.timeout), 32'd1);
    check("stall_1024", bus.stall_cnt, 32'd1024);
    bus.pause_req_ex = 0;
    idle(3);
    check("timeout_sticky", 32'(bus.timeout), 32'd1);
    check("stall_hold", bus.stall_cnt, 32'd1024);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_redirect: %0d events outstanding, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 1024, is the consecutive-stall cycle count that trips the watchdog.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 pause_req_if, pause_req_id, pause_req_ex, pause_req_mem  input  1 each  level stall requests from the IF, ID, EX and MEM stages.
REQ-005 hold  input  1  debug halt; freezes the whole pipeline.
REQ-006 excp_valid  input  1  one-cycle exception pulse from MEM.
REQ-007 excp_pc  input  32  exception target.
REQ-008 br_valid  input  1  one-cycle branch-mispredict pulse from EX.
REQ-009 br_pc  input  32  branch target.
REQ-010 pause  output  6  stage pause vector, same encoding the pipeline registers consume: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB.
REQ-011 flush  output  1  clears all pipeline registers.
REQ-012 flush_front  output  1  clears IF/ID and ID/EX only.
REQ-013 redirect_valid  output  1  PC load strobe.
REQ-014 redirect_pc  output  32  PC load value.
REQ-015 stall_cnt  output  32  saturating count of cycles with pause != 0.
REQ-016 timeout  output  1  sticky watchdog flag.

Function
REQ-017 pause SHALL be combinational: hold -> 6'b111111; else highest requesting stage: mem -> 6'b011111, ex -> 6'b001111, id -> 6'b000111, if -> 6'b000011; none -> 6'b000000.
REQ-018 pause SHALL be forced to 6'b000000 in any cycle where flush=1 and hold=0.
REQ-019 FSM states: RUN, FLUSH, FRONT.
- RUN -> FLUSH when an exception is accepted.
- RUN -> FRONT when a branch is accepted.
- FLUSH -> RUN and FRONT -> RUN after exactly one cycle.
REQ-020 An exception SHALL be accepted when the exception (live or pending) is present, pause_req_mem=0 and hold=0.
REQ-021 An accepted exception SHALL produce flush=1, redirect_valid=1 and redirect_pc=exception target in the next cycle (1-cycle latency).
REQ-022 An exception blocked by pause_req_mem or hold SHALL latch excp_pc into a pending register; acceptance follows the first unblocked cycle.
REQ-023 A newer excp_valid SHALL overwrite the pending target.
REQ-024 A branch SHALL be accepted when the branch (live or pending) is present, pause[3]=0 (EX not paused) and no exception is accepted that cycle.
REQ-025 An accepted branch SHALL produce flush_front=1, redirect_valid=1 and redirect_pc=branch target in the next cycle.
REQ-026 A blocked branch SHALL be held pending exactly like an exception.
REQ-027 Exception priority:
- An accepted exception SHALL discard any live or pending branch.
- A simultaneous excp_valid and br_valid SHALL yield only the exception.
REQ-028 flush, flush_front and redirect_valid SHALL be registered, each high for exactly one cycle per accepted event; flush and flush_front SHALL never be high together.
REQ-029 Events arriving while in FLUSH SHALL be discarded; only an exception arriving while in FRONT SHALL be latched pending.
REQ-030 stall_cnt SHALL increment by 1 each cycle pause != 0 and saturate at 32'hFFFFFFFF without wrapping.
REQ-031 Watchdog:
- A run counter SHALL count consecutive cycles with pause != 0 and hold=0.
- Any cycle with pause == 0 or hold=1 clears it.
- Reaching TIMEOUT sets timeout=1, which stays set until reset.

Reset
REQ-032 When rst=0, the block SHALL asynchronously set:
- state to RUN; flush, flush_front and redirect_valid to 0; redirect_pc to 32'h0.
- pending flags and targets to 0; stall_cnt, run counter and timeout to 0.
REQ-033 An event pending or in progress at reset assertion SHALL be lost; no redirect SHALL follow reset release.
REQ-034 pause SHALL follow only its inputs during reset.

Verification
REQ-035 pause_req_id=1 and pause_req_mem=1 together -> pause=6'b011111; hold=1 -> 6'b111111.
REQ-036 excp_valid with excp_pc=32'h1C00_0100 in cycle N, no stalls -> cycle N+1: flush=1, redirect_valid=1, redirect_pc=32'h1C00_0100; cycle N+2: all three 0.
REQ-037 excp_valid in cycle N with pause_req_mem high for cycles N..N+3 -> flush=1 at cycle N+5 with the latched pc, and none earlier.
REQ-038 excp_valid (pc 32'h80) and br_valid (pc 32'h40) in the same cycle -> one flush with redirect_pc=32'h80; flush_front never asserts.
REQ-039 pause_req_ex held 1024 cycles with TIMEOUT=1024 -> timeout=1 and stays 1 after the request drops; stall_cnt=1024.
REQ-040 rst pulsed low mid-stall with an exception pending -> outputs zero immediately; no flush after release.
